// File: rtl/usb_buf_pkg.sv
// rtl/usb_buf_pkg.sv - shared types and constants for the USB buffer arbiter
package usb_buf_pkg;

  localparam int ADDR_W_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic OWN_USB = 1'b0;
  localparam logic OWN_CPU = 1'b1;

endpackage

// File: rtl/usb_buf_arbiter.sv
// rtl/usb_buf_arbiter.sv - shares the endpoint buffer RAM between the USB engine and CPU word port
module usb_buf_arbiter
  import usb_buf_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_48,
  input  logic              rst_n,
  input  logic              avalid,
  output logic              aready,
  input  logic              awe,
  input  logic [ADDR_W-3:0] aaddr,
  input  logic [31:0]       adata,
  input  logic [3:0]        astrb,
  output logic              bvalid,
  output logic [31:0]       bdata,
  input  logic              usb_req,
  input  logic              usb_we,
  input  logic [ADDR_W-1:0] usb_addr,
  input  logic [7:0]        usb_wdata,
  output logic [7:0]        usb_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  state_t            state, state_nxt;
  logic [1:0]        idx, idx_nxt;
  logic              req_we;
  logic [ADDR_W-3:0] req_addr;
  logic [31:0]       req_data;
  logic [3:0]        req_strb;
  logic              accept;
  logic              cpu_issue;
  logic [ADDR_W-1:0] addr_hold;
  logic [7:0]        wdata_hold;
  logic              cap_valid;
  logic              cap_owner;
  logic [1:0]        cap_idx;

  assign accept    = (state == ST_IDLE) && avalid;
  assign cpu_issue = (state == ST_RUN) && !usb_req;
  assign aready    = (state == ST_RESP);
  assign bvalid    = (state == ST_RESP);

  // USB always wins the port; idle cycles keep the previous address on the bus.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = addr_hold;
    ram_wdata = wdata_hold;
    if (usb_req) begin
      ram_we    = usb_we;
      ram_addr  = usb_addr;
      ram_wdata = usb_wdata;
    end else if (cpu_issue) begin
      ram_we    = req_we & req_strb[idx];
      ram_addr  = {req_addr, idx};
      ram_wdata = req_data[{idx, 3'b000} +: 8];
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      ST_IDLE: begin
        if (avalid) begin
          state_nxt = ST_RUN;
          idx_nxt   = 2'd0;
        end
      end
      ST_RUN: begin
        if (!usb_req) begin
          if (idx == 2'd3) begin
            state_nxt = req_we ? ST_RESP : ST_DRAIN;
          end else begin
            idx_nxt = idx + 2'd1;
          end
        end
      end
      ST_DRAIN: state_nxt = ST_RESP;
      ST_RESP: begin
        state_nxt = ST_IDLE;
        idx_nxt   = 2'd0;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= 2'd0;
      req_we     <= 1'b0;
      req_addr   <= '0;
      req_data   <= '0;
      req_strb   <= '0;
      addr_hold  <= '0;
      wdata_hold <= '0;
      cap_valid  <= 1'b0;
      cap_owner  <= OWN_USB;
      cap_idx    <= 2'd0;
      bdata      <= '0;
      usb_rdata  <= '0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      addr_hold  <= ram_addr;
      wdata_hold <= ram_wdata;
      if (accept) begin
        req_we   <= awe;
        req_addr <= aaddr;
        req_data <= adata;
        req_strb <= astrb;
      end
      // Tag each read cycle so the byte is steered to its owner when RAM data returns.
      cap_valid <= (usb_req & ~usb_we) | (cpu_issue & ~req_we);
      cap_owner <= usb_req ? OWN_USB : OWN_CPU;
      cap_idx   <= idx;
      if (cap_valid) begin
        if (cap_owner == OWN_USB) begin
          usb_rdata <= ram_rdata;
        end else begin
          bdata[{cap_idx, 3'b000} +: 8] <= ram_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_usb_buf_arbiter.sv
// tb/tb_usb_buf_arbiter.sv - scoreboard bench for usb_buf_arbiter with a RAM model
module tb_usb_buf_arbiter;

  localparam int AW = 10;

  logic          clk_48 = 1'b0;
  logic          rst_n = 1'b0;
  logic          avalid = 1'b0;
  logic          awe = 1'b0;
  logic [AW-3:0] aaddr = '0;
  logic [31:0]   adata = '0;
  logic [3:0]    astrb = '0;
  logic          aready;
  logic          bvalid;
  logic [31:0]   bdata;
  logic          usb_req = 1'b0;
  logic          usb_we = 1'b0;
  logic [AW-1:0] usb_addr = '0;
  logic [7:0]    usb_wdata = '0;
  logic [7:0]    usb_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata;

  always #5 clk_48 = ~clk_48;

  usb_buf_arbiter #(.ADDR_W(AW)) dut (
    .clk_48(clk_48), .rst_n(rst_n),
    .avalid(avalid), .aready(aready), .awe(awe), .aaddr(aaddr), .adata(adata), .astrb(astrb),
    .bvalid(bvalid), .bdata(bdata),
    .usb_req(usb_req), .usb_we(usb_we), .usb_addr(usb_addr), .usb_wdata(usb_wdata), .usb_rdata(usb_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  logic [7:0] ram [0:1023];
  always @(posedge clk_48) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  typedef struct { int cyc; logic [9:0] addr; logic [7:0] data; } wr_t;
  typedef struct { int cyc; logic [31:0] data; } rsp_t;
  typedef struct { int cyc; logic [7:0] data; } ur_t;

  wr_t  wq[$];
  rsp_t rq[$];
  ur_t  uq[$];

  logic [7:0]  ref_mem [0:1023];
  logic [31:0] last_rd = '0;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          cur_pre = 0;
  logic [15:0] cur_mask = '0;
  int          fix_uaddr = -1;

  always @(posedge clk_48) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic bit steal_at(input int n);
    if (n <= cur_pre) return 1'b1;
    if (n - cur_pre - 1 < 16) return cur_mask[n - cur_pre - 1];
    return 1'b0;
  endfunction

  task automatic drive_usb(input bit on);
    ur_t u;
    if (!on) begin
      usb_req = 1'b0;
      usb_we  = 1'b0;
      return;
    end
    usb_req   = 1'b1;
    usb_we    = (fix_uaddr >= 0) ? 1'b0 : 1'($urandom_range(0, 1));
    usb_addr  = (fix_uaddr >= 0) ? fix_uaddr[9:0] : 10'h300 + 10'($urandom_range(0, 255));
    usb_wdata = 8'($urandom);
    if (usb_we) begin
      ref_mem[usb_addr] = usb_wdata;
    end else begin
      u.cyc  = cyc + 2;
      u.data = ref_mem[usb_addr];
      uq.push_back(u);
    end
  endtask

  task automatic usb_write(input logic [9:0] a, input logic [7:0] d);
    @(posedge clk_48); #1;
    usb_req = 1'b1; usb_we = 1'b1; usb_addr = a; usb_wdata = d;
    ref_mem[a] = d;
  endtask

  // Reference: byte k issues on the k-th cycle without USB traffic; response follows 1 (write) or 2 (read) cycles later.
  task automatic cpu_req(input bit we, input logic [7:0] wa, input logic [31:0] d, input logic [3:0] s,
                         input int pre, input logic [15:0] mask);
    int n, t, k;
    wr_t w;
    rsp_t r;
    cur_pre = pre;
    cur_mask = mask;
    @(posedge clk_48); #1;
    drive_usb(1'b0);
    avalid = 1'b1; awe = we; aaddr = wa; adata = d; astrb = s;
    t = cyc;
    k = 0;
    n = 0;
    while (k < 4) begin
      n++;
      if (!steal_at(n)) begin
        if (we && s[k]) begin
          w.cyc = t + n; w.addr = {wa, k[1:0]}; w.data = d[8*k +: 8];
          wq.push_back(w);
        end
        k++;
      end
    end
    if (we) begin
      for (int b = 0; b < 4; b++) if (s[b]) ref_mem[{wa, b[1:0]}] = d[8*b +: 8];
      r.cyc = t + n + 1;
      r.data = last_rd;
    end else begin
      for (int b = 0; b < 4; b++) r.data[8*b +: 8] = ref_mem[{wa, b[1:0]}];
      last_rd = r.data;
      r.cyc = t + n + 2;
    end
    rq.push_back(r);
    n = 0;
    forever begin
      @(posedge clk_48); #1;
      n++;
      drive_usb(steal_at(n));
      if (aready) break;
      if (n > 400) begin
        chk("req_timeout", 32'(n), 32'd0);
        break;
      end
    end
    @(posedge clk_48); #1;
    avalid = 1'b0;
    drive_usb(1'b0);
  endtask

  always @(negedge clk_48) begin : monitor
    wr_t w;
    rsp_t r;
    ur_t u;
    if (rst_n) begin
      while (wq.size() > 0 && wq[0].cyc < cyc) begin
        w = wq.pop_front();
        chk("cpu_write_missing_addr", 32'h0, 32'(w.addr));
      end
      if (usb_req) begin
        chk("usb_addr_mux", 32'(ram_addr), 32'(usb_addr));
        chk("usb_we_mux", 32'(ram_we), 32'(usb_we));
        if (usb_we) chk("usb_wdata_mux", 32'(ram_wdata), 32'(usb_wdata));
      end else if (ram_we) begin
        if (wq.size() == 0) begin
          chk("cpu_write_unexpected_addr", 32'(ram_addr), 32'hFFFF);
        end else begin
          w = wq.pop_front();
          chk("cpu_write_cycle", 32'(cyc), 32'(w.cyc));
          chk("cpu_write_addr", 32'(ram_addr), 32'(w.addr));
          chk("cpu_write_data", 32'(ram_wdata), 32'(w.data));
        end
      end
      if (bvalid) begin
        if (rq.size() == 0) begin
          chk("bvalid_unexpected", 32'(bvalid), 32'h0);
        end else begin
          r = rq.pop_front();
          chk("resp_cycle", 32'(cyc), 32'(r.cyc));
          chk("resp_bdata", bdata, r.data);
          chk("resp_aready", 32'(aready), 32'h1);
        end
      end else if (aready) begin
        chk("aready_without_bvalid", 32'(aready), 32'h0);
      end
      while (uq.size() > 0 && uq[0].cyc <= cyc) begin
        u = uq.pop_front();
        chk("usb_rdata", 32'(usb_rdata), 32'(u.data));
      end
    end
  end

  task automatic chk_reset_outputs();
    chk("rst_aready", 32'(aready), 32'h0);
    chk("rst_bvalid", 32'(bvalid), 32'h0);
    chk("rst_bdata", bdata, 32'h0);
    chk("rst_usb_rdata", 32'(usb_rdata), 32'h0);
    chk("rst_ram_we", 32'(ram_we), 32'h0);
    chk("rst_ram_addr", 32'(ram_addr), 32'h0);
    chk("rst_ram_wdata", 32'(ram_wdata), 32'h0);
  endtask

  initial begin : watchdog
    #2000000;
    chk("global_timeout", 32'(cyc), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int t;
    wr_t w;
    repeat (3) @(posedge clk_48);
    #1;
    chk_reset_outputs();
    rst_n = 1'b1;

    for (int i = 0; i < 1024; i++) usb_write(10'(i), 8'($urandom));
    @(posedge clk_48); #1;
    drive_usb(1'b0);

    cpu_req(1'b1, 8'h10, 32'hA1B2C3D4, 4'hF, 0, 16'h0);
    cpu_req(1'b0, 8'h10, 32'h0, 4'h0, 0, 16'h0);
    cpu_req(1'b1, 8'h11, 32'hFFFFFFFF, 4'hF, 0, 16'h0);
    cpu_req(1'b1, 8'h11, 32'h11223344, 4'b0101, 0, 16'h0);
    cpu_req(1'b0, 8'h11, 32'h0, 4'h0, 0, 16'h0);

    usb_write(10'h3FF, 8'h5A);
    @(posedge clk_48); #1;
    drive_usb(1'b0);
    fix_uaddr = 10'h3FF;
    cpu_req(1'b0, 8'h10, 32'h0, 4'h0, 0, 16'b0110);
    fix_uaddr = -1;

    cpu_req(1'b1, 8'h30, $urandom, 4'hF, 100, 16'h0);
    cpu_req(1'b0, 8'h30, 32'h0, 4'h0, 0, 16'h0);

    for (int i = 0; i < 40; i++) begin
      cpu_req(1'($urandom_range(0, 1)), 8'($urandom_range(0, 8'hBF)), $urandom, 4'($urandom),
              0, 16'($urandom & $urandom & $urandom));
    end

    cpu_req(1'b1, 8'h20, 32'h11111111, 4'hF, 0, 16'h0);
    @(posedge clk_48); #1;
    avalid = 1'b1; awe = 1'b1; aaddr = 8'h20; adata = 32'h22222222; astrb = 4'hF;
    t = cyc;
    w.cyc = t + 1; w.addr = 10'h080; w.data = 8'h22; wq.push_back(w);
    w.cyc = t + 2; w.addr = 10'h081; w.data = 8'h22; wq.push_back(w);
    repeat (3) @(posedge clk_48);
    #1;
    rst_n = 1'b0;
    avalid = 1'b0;
    #1;
    chk_reset_outputs();
    ref_mem[10'h080] = 8'h22;
    ref_mem[10'h081] = 8'h22;
    last_rd = 32'h0;
    @(posedge clk_48); #1;
    rst_n = 1'b1;
    cpu_req(1'b0, 8'h20, 32'h0, 4'h0, 0, 16'h0);

    repeat (4) @(posedge clk_48);
    #1;
    chk("pending_cpu_writes", 32'(wq.size()), 32'h0);
    chk("pending_responses", 32'(rq.size()), 32'h0);
    chk("pending_usb_reads", 32'(uq.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
